score_display_scanner: RTL and testbench

Downstream output stage of the card-game top level. It takes the two players' chip or score values as binary words, converts each to four BCD digits with a sequential double-dabble engine, and time-multiplexes the resulting eight digits onto the shared seven-segment bus `os_ENS`/`os_COM`. Player 1 occupies digits 7..4 and player 2 occupies digits 3..0. Values are loaded by a one-cycle strobe from the result stage; the display keeps showing the last committed values until a new conversion completes.

---
 rtl/display_pkg.sv | 61 ++++++
 rtl/bin2bcd_seq.sv | 65 ++++++
 rtl/score_display_scanner.sv | 147 ++++++++++++++
 tb/tb_score_display_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, segment codes and digit helpers for the score display scanner.
// A digit nibble of 4'hF marks a blanked position; valid BCD never exceeds 9.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV1  = 2'd1,
    CONV2  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] COM_OFF     = 8'hFF;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Replace leading zero digits of a 4-digit group with blanks; units always shown.
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
    logic [15:0] result;
    logic        leading;
    result  = bcd;
    leading = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (leading && (bcd[i*4 +: 4] == 4'd0)) begin
        result[i*4 +: 4] = DIGIT_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one bit per cycle, VAL_W cycles per value.
// The first shift happens on the start cycle; done flags the cycle of the final shift.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VAL_W = 10
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [VAL_W-1:0] bin_in,
  output logic             done,
  output logic [15:0]      bcd_out
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [15:0]      acc_q;
  logic [VAL_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [VAL_W-1:0] src;
  logic [15:0]      base;
  logic [11:0]      lowAdj;
  logic [2:0]       topAdj;

  // bcd_out is the accumulator after this cycle's adjust-and-shift step.
  always_comb begin
    src    = start ? bin_in : shift_q;
    base   = start ? 16'h0000 : acc_q;
    lowAdj = 12'h000;
    for (int i = 0; i < 3; i++) begin
      lowAdj[i*4 +: 4] = (base[i*4 +: 4] >= 4'd5) ? base[i*4 +: 4] + 4'd3 : base[i*4 +: 4];
    end
    topAdj  = 3'((base[15:12] >= 4'd5) ? base[15:12] + 4'd3 : base[15:12]);
    bcd_out = {topAdj, lowAdj, src[VAL_W-1]};
    done    = run_q && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= 16'h0000;
      shift_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      acc_q   <= bcd_out;
      shift_q <= bin_in << 1;
      cnt_q   <= CNT_W'(VAL_W - 1);
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CNT_W'(1)) begin
        acc_q <= 16'h0000;
        cnt_q <= '0;
        run_q <= 1'b0;
      end else begin
        acc_q   <= bcd_out;
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// Converts two player values to BCD and scans them onto an 8-digit seven-segment bus.
// Player 1 drives digits 7..4, player 2 digits 3..0; both groups commit together.
module score_display_scanner
  import display_pkg::*;
#(
  parameter int VAL_W    = 10,
  parameter int SCAN_DIV = 10000
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             load,
  input  logic [VAL_W-1:0] p1_value,
  input  logic [VAL_W-1:0] p2_value,
  output logic             busy,
  output logic [7:0]       os_ENS,
  output logic [7:0]       os_COM
);

  localparam int PSC_W = $clog2(SCAN_DIV);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             start_q, start_d;
  logic [VAL_W-1:0] p1Shadow_q, p1Shadow_d;
  logic [VAL_W-1:0] p2Shadow_q, p2Shadow_d;
  logic [15:0]      stage1_q, stage1_d;
  logic [15:0]      stage2_q, stage2_d;
  logic [31:0]      digits_q, digits_d;

  logic [PSC_W-1:0] psc_q;
  logic [2:0]       idx_q;
  logic [7:0]       com_q;
  logic [7:0]       ens_q;

  logic             engDone;
  logic [15:0]      engBcd;
  logic [VAL_W-1:0] engIn;

  assign engIn = (state_q == CONV2) ? p2Shadow_q : p1Shadow_q;

  bin2bcd_seq #(
    .VAL_W (VAL_W)
  ) u_bin2bcd (
    .clk     (clk),
    .nRST    (nRST),
    .start   (start_q),
    .bin_in  (engIn),
    .done    (engDone),
    .bcd_out (engBcd)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    start_d    = 1'b0;
    p1Shadow_d = p1Shadow_q;
    p2Shadow_d = p2Shadow_q;
    stage1_d   = stage1_q;
    stage2_d   = stage2_q;
    digits_d   = digits_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          p1Shadow_d = p1_value;
          p2Shadow_d = p2_value;
          start_d    = 1'b1;
          state_d    = CONV1;
        end
      end
      CONV1: begin
        if (load) pend_d = 1'b1;
        if (engDone) begin
          stage1_d = engBcd;
          start_d  = 1'b1;
          state_d  = CONV2;
        end
      end
      CONV2: begin
        if (load) pend_d = 1'b1;
        if (engDone) begin
          stage2_d = engBcd;
          state_d  = COMMIT;
        end
      end
      COMMIT: begin
        digits_d = {blank_leading(stage1_q), blank_leading(stage2_q)};
        // A load seen in this cycle is folded into the pending restart.
        if (pend_q || load) begin
          pend_d     = 1'b0;
          p1Shadow_d = p1_value;
          p2Shadow_d = p2_value;
          start_d    = 1'b1;
          state_d    = CONV1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      start_q    <= 1'b0;
      p1Shadow_q <= '0;
      p2Shadow_q <= '0;
      stage1_q   <= 16'h0000;
      stage2_q   <= 16'h0000;
      digits_q   <= {8{DIGIT_BLANK}};
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      start_q    <= start_d;
      p1Shadow_q <= p1Shadow_d;
      p2Shadow_q <= p2Shadow_d;
      stage1_q   <= stage1_d;
      stage2_q   <= stage2_d;
      digits_q   <= digits_d;
    end
  end

  // Free-running scan; outputs are registered from the current index.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      psc_q <= '0;
      idx_q <= 3'd0;
      com_q <= COM_OFF;
      ens_q <= SEG_BLANK;
    end else begin
      if (psc_q == PSC_W'(SCAN_DIV - 1)) begin
        psc_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        psc_q <= psc_q + PSC_W'(1);
      end
      com_q <= ~(8'h01 << idx_q);
      ens_q <= bcd_to_seg(digits_q[{idx_q, 2'b00} +: 4]);
    end
  end

  assign busy   = (state_q != IDLE);
  assign os_COM = com_q;
  assign os_ENS = ens_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with VAL_W=10, SCAN_DIV=4.
// Expected segment patterns are hand-derived from the decimal value of each load.
module tb_score_display_scanner;

  localparam int VAL_W    = 10;
  localparam int SCAN_DIV = 4;

  logic             clk  = 1'b0;
  logic             nRST = 1'b0;
  logic             load = 1'b0;
  logic [VAL_W-1:0] p1   = '0;
  logic [VAL_W-1:0] p2   = '0;
  logic             busy;
  logic [7:0]       osEns;
  logic [7:0]       osCom;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_display_scanner #(
    .VAL_W    (VAL_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .load     (load),
    .p1_value (p1),
    .p2_value (p2),
    .busy     (busy),
    .os_ENS   (osEns),
    .os_COM   (osCom)
  );

  task automatic startLoad(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
    @(negedge clk);
    p1   = a;
    p2   = b;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Counts further post-edge samples with busy high; bounded so a stuck busy ends.
  task automatic countBusy(input int nIn, output int nOut);
    nOut = nIn;
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk);
      #1;
      if (busy) nOut++;
    end
  endtask

  task automatic readDigits(output logic [63:0] segs, output logic [7:0] found);
    logic [7:0] sel;
    segs  = '0;
    found = '0;
    for (int n = 0; n < 8; n++) begin
      sel = 8'h01 << n;
      sel = ~sel;
      for (int c = 0; c < 3 * 8 * SCAN_DIV && !found[n]; c++) begin
        @(posedge clk);
        #1;
        if (osCom === sel) begin
          found[n]        = 1'b1;
          segs[n*8 +: 8]  = osEns;
        end
      end
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (osCom !== 8'hFF) begin bad++; $display("[TB] FAIL reset_com: got %h want ff", osCom); end
    total++;
    if (osEns !== 8'h00) begin bad++; $display("[TB] FAIL reset_ens: got %h want 00", osEns); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (osCom !== 8'hFE) begin bad++; $display("[TB] FAIL first_scan_com: got %h want fe", osCom); end
    total++;
    if (osEns !== 8'h00) begin bad++; $display("[TB] FAIL first_scan_ens: got %h want 00", osEns); end
  endtask

  task automatic test_scan_order;
    logic [7:0] want;
    for (int k = 1; k < 36; k++) begin
      @(posedge clk);
      #1;
      want = 8'h01 << ((k / SCAN_DIV) % 8);
      want = ~want;
      total++;
      if (osCom !== want) begin
        bad++;
        $display("[TB] FAIL scan_order k=%0d: got %h want %h", k, osCom, want);
      end
    end
  endtask

  task automatic test_basic;
    logic [63:0] segs;
    logic [7:0]  found;
    logic [63:0] exp;
    int          n;
    exp = {8'h00, 8'h00, 8'h00, 8'h3F, 8'h06, 8'h3F, 8'h5B, 8'h4F};
    startLoad(10'd0, 10'd1023);
    countBusy(busy ? 1 : 0, n);
    total++;
    if (n != 21) begin bad++; $display("[TB] FAIL basic_busy_len: got %0d want 21", n); end
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== exp[d*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL basic_digit%0d: got %h (seen=%b) want %h", d, segs[d*8 +: 8], found[d], exp[d*8 +: 8]);
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [63:0] segs;
    logic [7:0]  found;
    logic [63:0] exp;
    int          n;
    exp = {8'h00, 8'h00, 8'h66, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h07};
    startLoad(10'd40, 10'd7);
    countBusy(busy ? 1 : 0, n);
    total++;
    if (n != 21) begin bad++; $display("[TB] FAIL lz_busy_len: got %0d want 21", n); end
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== exp[d*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL lz_digit%0d: got %h (seen=%b) want %h", d, segs[d*8 +: 8], found[d], exp[d*8 +: 8]);
      end
    end
  endtask

  task automatic test_load_while_busy;
    logic [63:0] segs;
    logic [7:0]  found;
    logic [63:0] exp;
    int          n;
    exp = {8'h00, 8'h5B, 8'h6D, 8'h3F, 8'h00, 8'h00, 8'h4F, 8'h7D};
    startLoad(10'd5, 10'd9);
    n = busy ? 1 : 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (busy) n++;
    end
    @(negedge clk);
    p1   = 10'd250;
    p2   = 10'd36;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (busy) n++;
    countBusy(n, n);
    total++;
    if (n != 42) begin bad++; $display("[TB] FAIL pend_busy_len: got %0d want 42", n); end
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== exp[d*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL pend_digit%0d: got %h (seen=%b) want %h", d, segs[d*8 +: 8], found[d], exp[d*8 +: 8]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] segs;
    logic [7:0]  found;
    logic [63:0] exp;
    int          n;
    exp = {8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h6F, 8'h6F, 8'h6F};
    startLoad(10'd3, 10'd4);
    n = busy ? 1 : 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) n++;
    end
    @(negedge clk);
    p1   = 10'd1000;
    p2   = 10'd999;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (busy) n++;
    countBusy(n, n);
    total++;
    if (n != 42) begin bad++; $display("[TB] FAIL b2b_busy_len: got %0d want 42", n); end
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== exp[d*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL b2b_digit%0d: got %h (seen=%b) want %h", d, segs[d*8 +: 8], found[d], exp[d*8 +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] segs;
    logic [7:0]  found;
    logic [63:0] exp;
    int          n;
    startLoad(10'd77, 10'd88);
    repeat (14) @(posedge clk);
    #3;
    nRST = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    total++;
    if (osCom !== 8'hFF) begin bad++; $display("[TB] FAIL midrst_com: got %h want ff", osCom); end
    @(negedge clk);
    nRST = 1'b1;
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== 8'h00) begin
        bad++;
        $display("[TB] FAIL midrst_blank%0d: got %h (seen=%b) want 00", d, segs[d*8 +: 8], found[d]);
      end
    end
    exp = {8'h00, 8'h00, 8'h06, 8'h5B, 8'h00, 8'h4F, 8'h66, 8'h6D};
    startLoad(10'd12, 10'd345);
    countBusy(busy ? 1 : 0, n);
    total++;
    if (n != 21) begin bad++; $display("[TB] FAIL midrst_busy_len: got %0d want 21", n); end
    readDigits(segs, found);
    for (int d = 0; d < 8; d++) begin
      total++;
      if (!found[d] || segs[d*8 +: 8] !== exp[d*8 +: 8]) begin
        bad++;
        $display("[TB] FAIL midrst_digit%0d: got %h (seen=%b) want %h", d, segs[d*8 +: 8], found[d], exp[d*8 +: 8]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan_order;
    test_basic;
    test_leading_zero;
    test_load_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
